// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every MAX_RUN consecutive 1s,
// stalling the upstream queue for the stuffed cycle, and frames the packet.
module bit_stuffer #(
  parameter int MAX_RUN = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             start_b,
  input  logic             endb,
  output logic             pause,
  output logic             s_out,
  output logic             out_valid,
  output logic             start_o,
  output logic             end_o,
  output logic [CNT_W-1:0] stuff_cnt,
  output logic [1:0]       o_dbg_state
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAIL   = 2'd2
  } state_t;

  state_t           r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_first;
  logic             r_s_out;
  logic             r_out_valid;
  logic             r_start_o;
  logic             r_end_o;
  logic [CNT_W-1:0] r_stuff_cnt;

  logic w_stuff;
  logic w_cnt_max;

  // Handshake: upstream presents s_in every ACTIVE cycle; it is consumed on
  // the rising edge when pause=0 and endb=0, otherwise it must be held.
  assign w_stuff   = (r_state == ACTIVE) && (r_run == RUN_W'(MAX_RUN));
  assign w_cnt_max = (r_stuff_cnt == {CNT_W{1'b1}});
  assign pause     = w_stuff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_first     <= 1'b0;
      r_s_out     <= 1'b0;
      r_out_valid <= 1'b0;
      r_start_o   <= 1'b0;
      r_end_o     <= 1'b0;
      r_stuff_cnt <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_start_o   <= 1'b0;
      r_end_o     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_b) begin
            r_state     <= ACTIVE;
            r_run       <= '0;
            r_stuff_cnt <= '0;
            r_first     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (w_stuff) begin
            // Stuffed 0 is emitted whether or not the packet is ending.
            r_s_out     <= 1'b0;
            r_out_valid <= 1'b1;
            r_start_o   <= r_first;
            r_first     <= 1'b0;
            r_run       <= '0;
            if (!w_cnt_max) r_stuff_cnt <= r_stuff_cnt + 1'b1;
            if (endb) r_state <= TAIL;
          end else if (endb) begin
            r_end_o <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_s_out     <= s_in;
            r_out_valid <= 1'b1;
            r_start_o   <= r_first;
            r_first     <= 1'b0;
            r_run       <= s_in ? r_run + 1'b1 : '0;
          end
        end
        TAIL: begin
          r_end_o <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_out       = r_s_out;
  assign out_valid   = r_out_valid;
  assign start_o     = r_start_o;
  assign end_o       = r_end_o;
  assign stuff_cnt   = r_stuff_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: doc/bit_stuffer.md
# bit_stuffer

USB transmit bit stuffer, directly downstream of the CRC stage. It consumes the serial packet stream (SYNC/PID/payload/CRC) that the CRC stage drains from its queue. After every `MAX_RUN` consecutive 1s it inserts a 0, holding the upstream queue with `pause` for that cycle. The stuffed stream, with start and end markers, goes to the NRZI encoder.

## Interface
- `MAX_RUN`, 6: run of consecutive 1s that forces a stuffed 0.
- `CNT_W`, 8: width of the per-packet stuffed-bit counter (saturating).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_in` in 1: serial bit from the CRC stage queue output.
- `start_b` in 1: one-cycle pulse; packet begins, first valid `s_in` on the next cycle.
- `endb` in 1: one-cycle pulse; upstream queue is empty, and `s_in` is not valid this cycle.
- `pause` out 1: combinational decode of state; 1 means `s_in` is not consumed this cycle, and upstream must hold it.
- `s_out` out 1: registered stuffed bit to NRZI.
- `out_valid` out 1: registered; `s_out` is valid.
- `start_o` out 1: registered pulse coincident with the first `out_valid` of a packet.
- `end_o` out 1: registered pulse one cycle after the last `out_valid` of a packet.
- `stuff_cnt` out CNT_W: number of bits stuffed in the current/last packet; stable from `end_o` until the next `start_b`.

## Operation
- Internal ones counter `run` (width ceil(log2(MAX_RUN+1))) counts consecutive 1s already decided for output; it clears on any 0 decided (data or stuffed).
- States: IDLE, ACTIVE, TAIL.
- IDLE: `pause`=0. Nothing is consumed and no output is produced.
  - `start_b`=1 → ACTIVE; clear `run`, clear `stuff_cnt`, arm `start_o` for the first emitted bit.
  - `endb` in IDLE is ignored.
- ACTIVE, `endb`=0:
  - `run`==MAX_RUN: decide stuffed 0, `pause`=1, `run`←0, `stuff_cnt`++ (saturating). `s_in` is not consumed.
  - Otherwise: `pause`=0 and `s_in` is consumed and decided for output. `run`←`run`+1 if `s_in`=1, else `run`←0.
- ACTIVE, `endb`=1 (`s_in` ignored):
  - `run`==MAX_RUN: decide the trailing stuffed 0, `stuff_cnt`++, → TAIL. `pause`=1 is harmless here.
  - Otherwise: no bit decided; `end_o` fires next cycle; → IDLE.
- TAIL: no bit decided; `end_o` fires next cycle; → IDLE.
- `start_b` while in ACTIVE or TAIL is ignored; packets never overlap.
- Every decided bit appears on `s_out` with `out_valid`=1 on the following cycle. `start_o` accompanies the first such bit.
- A bit stuffed at packet end is mandatory; it is always emitted before `end_o`.

## Timing
- Reset values: state IDLE, `run`=0, `s_out`=0, `out_valid`=0, `start_o`=0, `end_o`=0, `stuff_cnt`=0. `pause`=0 follows from IDLE.
- Reset mid-packet returns to IDLE immediately and discards the packet; no `end_o` is generated.
- Latency is 1 cycle from consumption of `s_in` to `s_out`.
- `pause` is high for exactly one cycle per stuff and never for two consecutive cycles.
- Throughput is one output bit per cycle while ACTIVE, whether data or stuffed.
- `end_o` comes 1 cycle after the last bit, or 2 cycles after `endb` when a trailing stuff occurs.
- Cycle of `start_b`: `s_in` is not sampled.
- A zero-length packet (`endb` on the cycle after `start_b`) produces no `out_valid` and no `start_o`; `end_o` still fires once.
- No downstream backpressure: the NRZI stage accepts one bit per cycle.

## Test plan
- Reset: hold `rst_n`=0, toggle inputs → all outputs 0, `pause`=0. Release; `start_b` without data then `endb` → single `end_o`, `out_valid` never 1.
- Packet 8'b0000_0001 (LSB first) → `s_out` identical, 8 `out_valid` cycles, `start_o` on the first, `end_o` one cycle after the last, `stuff_cnt`=0, `pause` never high.
- Seven 1s then 0 → output 1111110 1 0: `pause`=1 on the cycle after the sixth 1 is consumed, and the seventh 1 is held and emitted next; `stuff_cnt`=1.
- Exactly six 1s then `endb` → six 1s, a stuffed 0, then `end_o` two cycles after `endb`; `stuff_cnt`=1.
- Thirteen 1s then `endb` → stuffs after the 6th and 12th 1, output length 15, `stuff_cnt`=2. Assert that `s_out` never shows seven consecutive 1s.
- Assert `rst_n` mid-packet (`run`=4) → outputs return to reset values the same cycle. A new packet then starts with `run`=0: six 1s need their own stuff.
